tlp_traffic_source: RTL and testbench

//  Stimulus-side producer for the 4-lane PCIe transaction layer. Generates bursts of 10-bit

---
 rtl/tlp_pkg.sv | 24 ++
 rtl/tlp_payload_gen.sv | 33 +++
 rtl/tlp_traffic_source.sv | 150 +++++++++++++++
 tb/tb_tlp_traffic_source.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_pkg.sv
// Shared constants and FSM encoding for the TLP traffic source.
package tlp_pkg;

  localparam int unsigned DATA_W    = 10;
  localparam int unsigned LEN_W     = 5;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = $clog2(LANES);
  localparam int unsigned PAYLOAD_W = 8;
  localparam int unsigned DEST_MSB  = 9;
  localparam int unsigned DEST_LSB  = 8;
  localparam int unsigned DEST_W    = DEST_MSB - DEST_LSB + 1;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3
  localparam logic [PAYLOAD_W-1:0] LFSR_TAPS    = 8'hB8;
  localparam logic [PAYLOAD_W-1:0] PAYLOAD_SEED = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/tlp_payload_gen.sv
// Payload generator: LFSR when TLP_SRC_LFSR_EN is defined, otherwise a wrapping counter.
// Both start at PAYLOAD_SEED and step once per asserted advance.
module tlp_payload_gen
  import tlp_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
  output logic [PAYLOAD_W-1:0] payload
);

  logic [PAYLOAD_W-1:0] pl_q;
  logic [PAYLOAD_W-1:0] pl_d;

  always_comb begin
`ifdef TLP_SRC_LFSR_EN
    pl_d = {pl_q[PAYLOAD_W-2:0], ^(pl_q & LFSR_TAPS)};
`else
    pl_d = pl_q + 8'd1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pl_q <= PAYLOAD_SEED;
    end else if (advance) begin
      pl_q <= pl_d;
    end
  end

  assign payload = pl_q;

endmodule

// File: rtl/tlp_traffic_source.sv
// Burst producer for four input-FIFO lanes: round-robin over enabled lanes with
// almost_full backpressure. Payload style selected by TLP_SRC_LFSR_EN.
module tlp_traffic_source
  import tlp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [LANES-1:0]  lane_mask,
  input  logic              almost_full0,
  input  logic              almost_full1,
  input  logic              almost_full2,
  input  logic              almost_full3,
  output logic              push_out0,
  output logic              push_out1,
  output logic              push_out2,
  output logic              push_out3,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [LEN_W-1:0]  sent_count,
  output logic              busy,
  output logic              done
);

  state_e                 state_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       cnt_q;
  logic [LANES-1:0]       mask_q;
  logic [LANES-1:0]       push_q;
  logic [DATA_W-1:0]      data_q [LANES];
  logic [LANE_W-1:0]      rr_q;
  logic                   busy_q;
  logic                   done_q;

  logic [LANES-1:0]       af;
  logic [LANES-1:0]       elig;
  logic [LANE_W-1:0]      lane;
  logic [LANE_W-1:0]      pick_idx;
  logic                   pick_valid;
  logic                   advance;
  logic [PAYLOAD_W-1:0]   payload;

  assign af   = {almost_full3, almost_full2, almost_full1, almost_full0};
  assign elig = mask_q & ~af;

  // First eligible lane scanning from rr upward, wrapping modulo LANES.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_q;
    lane       = '0;
    for (int k = 0; k < LANES; k++) begin
      lane = rr_q + LANE_W'(k);
      if (!pick_valid && elig[lane]) begin
        pick_valid = 1'b1;
        pick_idx   = lane;
      end
    end
  end

  assign advance = (state_q == ST_SEND) && !abort && pick_valid;

  tlp_payload_gen u_payload_gen (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .payload (payload)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      push_q  <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) data_q[i] <= '0;
    end else begin
      push_q <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q  <= burst_len;
            mask_q <= lane_mask;
            cnt_q  <= '0;
            if (burst_len == '0 || lane_mask == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SEND;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (abort) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (pick_valid) begin
            push_q[pick_idx] <= 1'b1;
            data_q[pick_idx] <= {cnt_q[DEST_W-1:0], payload};
            cnt_q            <= cnt_q + LEN_W'(1);
            rr_q             <= pick_idx + LANE_W'(1);
            if (cnt_q + LEN_W'(1) == len_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (abort) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (|elig) begin
            state_q <= ST_SEND;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign push_out0  = push_q[0];
  assign push_out1  = push_q[1];
  assign push_out2  = push_q[2];
  assign push_out3  = push_q[3];
  assign data_out0  = data_q[0];
  assign data_out1  = data_q[1];
  assign data_out2  = data_q[2];
  assign data_out3  = data_q[3];
  assign sent_count = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tlp_traffic_source.sv
// Directed bench for tlp_traffic_source; payload expectations follow TLP_SRC_LFSR_EN.
module tb_tlp_traffic_source;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [4:0] burst_len;
  logic [3:0] lane_mask;
  logic [3:0] af;
  logic       push_out0, push_out1, push_out2, push_out3;
  logic [9:0] data_out0, data_out1, data_out2, data_out3;
  logic [4:0] sent_count;
  logic       busy;
  logic       done;

  logic [3:0] pushes;
  logic [9:0] dout [4];
  logic [7:0] exp_pl;
  logic [7:0] pl_tab [8];
  int         checks   = 0;
  int         failures = 0;

  assign pushes  = {push_out3, push_out2, push_out1, push_out0};
  assign dout[0] = data_out0;
  assign dout[1] = data_out1;
  assign dout[2] = data_out2;
  assign dout[3] = data_out3;

  always #5 clk = ~clk;

  tlp_traffic_source dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .burst_len    (burst_len),
    .lane_mask    (lane_mask),
    .almost_full0 (af[0]),
    .almost_full1 (af[1]),
    .almost_full2 (af[2]),
    .almost_full3 (af[3]),
    .push_out0    (push_out0),
    .push_out1    (push_out1),
    .push_out2    (push_out2),
    .push_out3    (push_out3),
    .data_out0    (data_out0),
    .data_out1    (data_out1),
    .data_out2    (data_out2),
    .data_out3    (data_out3),
    .sent_count   (sent_count),
    .busy         (busy),
    .done         (done)
  );

  function automatic logic [7:0] next_pl(input logic [7:0] p);
`ifdef TLP_SRC_LFSR_EN
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    return p + 8'd1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input string tag, input int lane, input logic [1:0] dest,
                          input logic last);
    logic [3:0] m;
    m = 4'b0001;
    m = m << lane;
    cyc();
    chk({tag, "_push"}, 32'(pushes), 32'(m));
    chk({tag, "_data"}, 32'(dout[lane]), 32'({dest, exp_pl}));
    chk({tag, "_done"}, 32'(done), 32'(last));
    exp_pl = next_pl(exp_pl);
  endtask

  task automatic exp_quiet(input string tag, input logic exp_busy);
    cyc();
    chk({tag, "_push"}, 32'(pushes), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
  endtask

  initial begin
`ifdef TLP_SRC_LFSR_EN
    pl_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
`else
    pl_tab = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`endif
    exp_pl    = 8'h01;
    reset     = 1'b0;
    start     = 1'b1;
    abort     = 1'b0;
    burst_len = 5'd8;
    lane_mask = 4'hF;
    af        = 4'h0;

    // 1: reset held for 3 cycles with start asserted
    repeat (3) cyc();
    chk("rst_push", 32'(pushes), 32'd0);
    chk("rst_data", 32'({data_out3, data_out2, data_out1, data_out0}), 32'd0);
    chk("rst_cnt", 32'(sent_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    start = 1'b0;
    exp_quiet("post_rst", 1'b0);

    // 2: full-rate burst over all four lanes
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t2_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      exp_push("t2", k % 4, 2'(k), k == 7);
      chk("t2_tab", 32'(dout[k % 4][7:0]), 32'(pl_tab[k]));
    end
    chk("t2_cnt", 32'(sent_count), 32'd8);
    chk("t2_busy_end", 32'(busy), 32'd0);
    exp_quiet("t2_after", 1'b0);
    chk("t2_done_clr", 32'(done), 32'd0);
    chk("t2_cnt_hold", 32'(sent_count), 32'd8);

    // 3: mask 0101, lane 2 blocked for the first three decisions
    burst_len = 5'd6;
    lane_mask = 4'b0101;
    af        = 4'b0100;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    exp_push("t3a", 0, 2'd0, 1'b0);
    exp_push("t3b", 0, 2'd1, 1'b0);
    exp_push("t3c", 0, 2'd2, 1'b0);
    af = 4'b0000;
    exp_push("t3d", 2, 2'd3, 1'b0);
    exp_push("t3e", 0, 2'd0, 1'b0);
    exp_push("t3f", 2, 2'd1, 1'b1);
    chk("t3_cnt", 32'(sent_count), 32'd6);
    exp_quiet("t3_after", 1'b0);

    // 4: stall everything after two pushes, then release only lane 3 (rr starts at 3)
    burst_len = 5'd4;
    lane_mask = 4'hF;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    exp_push("t4a", 3, 2'd0, 1'b0);
    exp_push("t4b", 0, 2'd1, 1'b0);
    af = 4'hF;
    exp_quiet("t4_pause1", 1'b1);
    exp_quiet("t4_pause2", 1'b1);
    af = 4'b0111;
    exp_quiet("t4_resume", 1'b1);
    exp_push("t4c", 3, 2'd2, 1'b0);
    exp_push("t4d", 3, 2'd3, 1'b1);
    af = 4'h0;
    exp_quiet("t4_after", 1'b0);

    // 5: abort after three of ten words, then a zero-length burst
    burst_len = 5'd10;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    exp_push("t5a", 0, 2'd0, 1'b0);
    exp_push("t5b", 1, 2'd1, 1'b0);
    exp_push("t5c", 2, 2'd2, 1'b0);
    abort = 1'b1;
    exp_quiet("t5_abort", 1'b0);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_cnt", 32'(sent_count), 32'd3);
    abort = 1'b0;
    exp_quiet("t5_after", 1'b0);
    chk("t5_done_clr", 32'(done), 32'd0);

    burst_len = 5'd0;
    start     = 1'b1;
    exp_quiet("t5_zero", 1'b0);
    start = 1'b0;
    chk("t5_zero_done", 32'(done), 32'd1);
    chk("t5_zero_cnt", 32'(sent_count), 32'd0);
    exp_quiet("t5_zero_after", 1'b0);
    chk("t5_zero_done_clr", 32'(done), 32'd0);

    // 6: reset mid-burst restarts the payload sequence and the round-robin pointer
    burst_len = 5'd8;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    exp_push("t6a", 3, 2'd0, 1'b0);
    exp_push("t6b", 0, 2'd1, 1'b0);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_push", 32'(pushes), 32'd0);
    chk("t6_rst_cnt", 32'(sent_count), 32'd0);
    chk("t6_rst_data0", 32'(data_out0), 32'd0);
    cyc();
    reset  = 1'b1;
    exp_pl = 8'h01;
    burst_len = 5'd3;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_push("t6", k, 2'(k), k == 2);
      chk("t6_tab", 32'(dout[k][7:0]), 32'(pl_tab[k]));
    end
    chk("t6_cnt", 32'(sent_count), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
